// File: rtl/modulo_mef_contador_param.sv
// Counter-control FSM: loads a terminal value, counts up or down to it, then
// issues a register-clear, with optional back-to-back reload from the buffer.
module modulo_mef_contador_param #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             load_reg,
    input  logic             empty_buffer,
    input  logic [WIDTH-1:0] data_in,
    input  logic             up_down,
    input  logic             auto_reload,
    input  logic             abort,
    output logic             load_c,
    output logic             enable_c,
    output logic             clear_reg,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] count,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        LOAD  = 2'b01,
        COUNT = 2'b10,
        CLEAR = 2'b11
    } state_t;

    state_t           cur_state;
    logic [WIDTH-1:0] count_reg;
    logic [WIDTH-1:0] target;
    logic             dir;
    logic             done_reg;
    logic             terminal;
    logic             request;

    // Up-counts finish on the loaded value, down-counts finish on zero.
    assign terminal = dir ? (count_reg == target) : (count_reg == '0);
    assign request  = load_reg & ~empty_buffer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_state <= IDLE;
            count_reg <= '0;
            target    <= '0;
            dir       <= 1'b0;
            done_reg  <= 1'b0;
        end else if (enable) begin
            case (cur_state)
                IDLE: begin
                    if (request) cur_state <= LOAD;
                end
                LOAD: begin
                    target    <= data_in;
                    dir       <= up_down;
                    count_reg <= up_down ? '0 : data_in;
                    done_reg  <= 1'b0;
                    cur_state <= (data_in == '0) ? CLEAR : COUNT;
                end
                COUNT: begin
                    // abort wins over terminal and leaves done untouched
                    if (abort) begin
                        cur_state <= CLEAR;
                    end else if (terminal) begin
                        cur_state <= CLEAR;
                        done_reg  <= 1'b1;
                    end else if (dir) begin
                        count_reg <= count_reg + WIDTH'(1);
                    end else begin
                        count_reg <= count_reg - WIDTH'(1);
                    end
                end
                CLEAR: begin
                    cur_state <= (auto_reload && request) ? LOAD : IDLE;
                end
                default: cur_state <= IDLE;
            endcase
        end
    end

    // Strobes are state decodes gated by enable, so a frozen block emits none.
    assign load_c    = (cur_state == LOAD) & enable;
    assign clear_reg = (cur_state == CLEAR) & enable;
    assign enable_c  = (cur_state == COUNT) & enable & ~terminal & ~abort;
    assign busy      = (cur_state != IDLE);
    assign done      = done_reg;
    assign count     = count_reg;
    assign state     = cur_state;

endmodule

// File: tb/tb_modulo_mef_contador_param.sv
// Cycle-by-cycle directed bench: each driven cycle queues its expected outputs,
// and a negedge monitor pops and compares them against the DUT.
module tb_modulo_mef_contador_param;

    localparam int W = 8;
    localparam logic [1:0] IDLE = 2'b00, LOAD = 2'b01, COUNT = 2'b10, CLEAR = 2'b11;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         enable = 1'b0, load_reg = 1'b0, empty_buffer = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         up_down = 1'b0, auto_reload = 1'b0, abort = 1'b0;
    logic         load_c, enable_c, clear_reg, busy, done;
    logic [W-1:0] count;
    logic [1:0]   state;

    logic [W+6:0] exp_q[$];
    string        tag_q[$];
    int           n_checks = 0;
    int           n_fail = 0;

    modulo_mef_contador_param #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .enable(enable), .load_reg(load_reg),
        .empty_buffer(empty_buffer), .data_in(data_in), .up_down(up_down),
        .auto_reload(auto_reload), .abort(abort), .load_c(load_c),
        .enable_c(enable_c), .clear_reg(clear_reg), .busy(busy), .done(done),
        .count(count), .state(state)
    );

    always #5 clk = ~clk;

    // Drive one cycle's inputs just after the edge and queue that cycle's expected outputs.
    task automatic cyc(input logic r, input logic en, input logic ld, input logic emp,
                       input logic ud, input logic ar, input logic ab, input logic [W-1:0] din,
                       input logic [1:0] st, input logic lc, input logic ec, input logic cr,
                       input logic dn, input logic [W-1:0] cnt, input string tag);
        @(posedge clk);
        #1;
        rst = r; enable = en; load_reg = ld; empty_buffer = emp;
        up_down = ud; auto_reload = ar; abort = ab; data_in = din;
        exp_q.push_back({st, lc, ec, cr, (st != IDLE), dn, cnt});
        tag_q.push_back(tag);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [W+6:0] e;
            logic [W+6:0] a;
            string        t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {state, load_c, enable_c, clear_reg, busy, done, count};
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL %s: got st=%0d lc=%b ec=%b cr=%b busy=%b done=%b cnt=%0d, expected st=%0d lc=%b ec=%b cr=%b busy=%b done=%b cnt=%0d",
                         t, a[W+6:W+5], a[W+4], a[W+3], a[W+2], a[W+1], a[W], a[W-1:0],
                         e[W+6:W+5], e[W+4], e[W+3], e[W+2], e[W+1], e[W], e[W-1:0]);
            end
        end
    end

    initial begin
        // reset state, request ignored while held in reset
        cyc(0,0,0,0,0,0,0,8'd0, IDLE,0,0,0,0,8'd0, "reset");
        cyc(0,1,1,0,0,0,0,8'd3, IDLE,0,0,0,0,8'd0, "reset_hold");

        // down count from 3
        cyc(1,1,1,0,0,0,0,8'd3, IDLE,0,0,0,0,8'd0, "dn3_req");
        cyc(1,1,0,0,0,0,0,8'd3, LOAD,1,0,0,0,8'd0, "dn3_load");
        cyc(1,1,0,0,0,0,0,8'd3, COUNT,0,1,0,0,8'd3, "dn3_c3");
        cyc(1,1,0,0,0,0,0,8'd3, COUNT,0,1,0,0,8'd2, "dn3_c2");
        cyc(1,1,0,0,0,0,0,8'd3, COUNT,0,1,0,0,8'd1, "dn3_c1");
        cyc(1,1,0,0,0,0,0,8'd3, COUNT,0,0,0,0,8'd0, "dn3_term");
        cyc(1,1,0,0,0,0,0,8'd3, CLEAR,0,0,1,1,8'd0, "dn3_clear");

        // up count to 4
        cyc(1,1,1,0,1,0,0,8'd4, IDLE,0,0,0,1,8'd0, "up4_req");
        cyc(1,1,0,0,1,0,0,8'd4, LOAD,1,0,0,1,8'd0, "up4_load");
        for (int i = 0; i < 4; i++)
            cyc(1,1,0,0,1,0,0,8'd4, COUNT,0,1,0,0,W'(i), "up4_step");
        cyc(1,1,0,0,1,0,0,8'd4, COUNT,0,0,0,0,8'd4, "up4_term");
        cyc(1,1,0,0,1,0,0,8'd4, CLEAR,0,0,1,1,8'd4, "up4_clear");

        // zero value: LOAD straight to CLEAR, done cleared and not set
        cyc(1,1,1,0,0,0,0,8'd0, IDLE,0,0,0,1,8'd4, "z_req");
        cyc(1,1,0,0,0,0,0,8'd0, LOAD,1,0,0,1,8'd4, "z_load");
        cyc(1,1,0,0,0,0,0,8'd0, CLEAR,0,0,1,0,8'd0, "z_clear");

        // enable low for two cycles at count 7 (down from 9)
        cyc(1,1,1,0,0,0,0,8'd9, IDLE,0,0,0,0,8'd0, "en_req");
        cyc(1,1,0,0,0,0,0,8'd9, LOAD,1,0,0,0,8'd0, "en_load");
        cyc(1,1,0,0,0,0,0,8'd9, COUNT,0,1,0,0,8'd9, "en_c9");
        cyc(1,1,0,0,0,0,0,8'd9, COUNT,0,1,0,0,8'd8, "en_c8");
        cyc(1,0,0,0,0,0,0,8'd9, COUNT,0,0,0,0,8'd7, "en_off1");
        cyc(1,0,0,0,0,0,0,8'd9, COUNT,0,0,0,0,8'd7, "en_off2");
        cyc(1,1,0,0,0,0,0,8'd9, COUNT,0,1,0,0,8'd7, "en_resume");
        for (int v = 6; v >= 1; v--)
            cyc(1,1,0,0,0,0,0,8'd9, COUNT,0,1,0,0,W'(v), "en_step");
        cyc(1,1,0,0,0,0,0,8'd9, COUNT,0,0,0,0,8'd0, "en_term");
        cyc(1,1,0,0,0,0,0,8'd9, CLEAR,0,0,1,1,8'd0, "en_clear");

        // abort coincident with terminal (up to 2), then abort and empty buffer in IDLE
        cyc(1,1,1,0,1,0,0,8'd2, IDLE,0,0,0,1,8'd0, "ab_req");
        cyc(1,1,0,0,1,0,0,8'd2, LOAD,1,0,0,1,8'd0, "ab_load");
        cyc(1,1,0,0,1,0,0,8'd2, COUNT,0,1,0,0,8'd0, "ab_c0");
        cyc(1,1,0,0,1,0,0,8'd2, COUNT,0,1,0,0,8'd1, "ab_c1");
        cyc(1,1,0,0,1,0,1,8'd2, COUNT,0,0,0,0,8'd2, "ab_term");
        cyc(1,1,0,0,1,0,0,8'd2, CLEAR,0,0,1,0,8'd2, "ab_clear");
        cyc(1,1,0,0,1,0,1,8'd2, IDLE,0,0,0,0,8'd2, "ab_idle");
        cyc(1,1,1,1,1,0,1,8'd2, IDLE,0,0,0,0,8'd2, "ab_idle_empty");

        // auto reload: 2 then 1, buffer goes empty in the second CLEAR
        cyc(1,1,1,0,0,1,0,8'd2, IDLE,0,0,0,0,8'd2, "ar_req");
        cyc(1,1,1,0,0,1,0,8'd2, LOAD,1,0,0,0,8'd2, "ar_load1");
        cyc(1,1,1,0,0,1,0,8'd1, COUNT,0,1,0,0,8'd2, "ar_c2");
        cyc(1,1,1,0,0,1,0,8'd1, COUNT,0,1,0,0,8'd1, "ar_c1");
        cyc(1,1,1,0,0,1,0,8'd1, COUNT,0,0,0,0,8'd0, "ar_term1");
        cyc(1,1,1,0,0,1,0,8'd1, CLEAR,0,0,1,1,8'd0, "ar_clear1");
        cyc(1,1,1,0,0,1,0,8'd1, LOAD,1,0,0,1,8'd0, "ar_load2");
        cyc(1,1,1,0,0,1,0,8'd1, COUNT,0,1,0,0,8'd1, "ar_c1b");
        cyc(1,1,1,0,0,1,0,8'd1, COUNT,0,0,0,0,8'd0, "ar_term2");
        cyc(1,1,1,1,0,1,0,8'd1, CLEAR,0,0,1,1,8'd0, "ar_clear2");
        cyc(1,1,0,0,0,0,0,8'd1, IDLE,0,0,0,1,8'd0, "ar_idle");

        // asynchronous reset while counting at 5 (down from 6)
        cyc(1,1,1,0,0,0,0,8'd6, IDLE,0,0,0,1,8'd0, "rs_req");
        cyc(1,1,0,0,0,0,0,8'd6, LOAD,1,0,0,1,8'd0, "rs_load");
        cyc(1,1,0,0,0,0,0,8'd6, COUNT,0,1,0,0,8'd6, "rs_c6");
        cyc(0,1,0,0,0,0,0,8'd6, IDLE,0,0,0,0,8'd0, "rs_async");
        cyc(0,1,0,0,0,0,0,8'd6, IDLE,0,0,0,0,8'd0, "rs_held");
        cyc(1,1,0,0,0,0,0,8'd6, IDLE,0,0,0,0,8'd0, "rs_release");
        cyc(1,1,0,0,0,0,0,8'd6, IDLE,0,0,0,0,8'd0, "rs_idle");

        @(posedge clk);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
